// File: rtl/number_chunk_replayer.sv
// Captures one wide number as a sequence of chunks, then replays the whole
// number NUM_REPEATS times, one complete pass per downstream request.
module number_chunk_replayer #(
  parameter int BITS_IN_NUM   = 4096,
  parameter int REGISTER_SIZE = 32,
  parameter int NUM_REPEATS   = 2
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [REGISTER_SIZE-1:0] data_in,
  input  logic                     data_valid_in,
  input  logic                     request_next_input,
  output logic [REGISTER_SIZE-1:0] data_out,
  output logic                     data_valid_out,
  output logic                     last_chunk_out,
  output logic                     ready_out,
  output logic                     input_dropped_out
);

  localparam int NUM_CHUNKS = BITS_IN_NUM / REGISTER_SIZE;
  localparam int IDX_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int PASS_W     = $clog2(NUM_REPEATS + 1);

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_CHUNKS - 1);
  localparam logic [PASS_W-1:0] PASS_MAX = PASS_W'(NUM_REPEATS);

  localparam logic [1:0] S_LOAD   = 2'd0;
  localparam logic [1:0] S_WAIT   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;

  logic [REGISTER_SIZE-1:0] mem_q [NUM_CHUNKS];

  logic [1:0]               state_q,    state_d;
  logic [IDX_W-1:0]         wr_idx_q,   wr_idx_d;
  logic [IDX_W-1:0]         rd_idx_q,   rd_idx_d;
  logic [PASS_W-1:0]        pass_cnt_q, pass_cnt_d;
  logic [REGISTER_SIZE-1:0] data_q,     data_d;
  logic                     valid_q,    valid_d;
  logic                     last_q,     last_d;
  logic                     drop_q,     drop_d;

  logic [PASS_W-1:0]        pass_inc;
  logic                     mem_we;

  assign pass_inc = pass_cnt_q + 1'b1;
  assign mem_we   = (state_q == S_LOAD) && data_valid_in;

  always_comb begin
    state_d    = state_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    pass_cnt_d = pass_cnt_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    last_d     = 1'b0;
    drop_d     = data_valid_in && (state_q != S_LOAD);

    case (state_q)
      S_LOAD: begin
        if (data_valid_in) begin
          wr_idx_d = wr_idx_q + 1'b1;
          if (wr_idx_q == LAST_IDX) begin
            wr_idx_d   = '0;
            pass_cnt_d = '0;
            state_d    = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (request_next_input) begin
          rd_idx_d = '0;
          state_d  = S_STREAM;
        end
      end
      S_STREAM: begin
        data_d   = mem_q[rd_idx_q];
        valid_d  = 1'b1;
        rd_idx_d = rd_idx_q + 1'b1;
        if (rd_idx_q == LAST_IDX) begin
          last_d     = 1'b1;
          rd_idx_d   = '0;
          pass_cnt_d = pass_inc;
          state_d    = (pass_inc == PASS_MAX) ? S_LOAD : S_WAIT;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Storage is deliberately left out of reset; only the control path clears.
  always_ff @(posedge clk_in) begin
    if (mem_we) mem_q[wr_idx_q] <= data_in;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= S_LOAD;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      pass_cnt_q <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      pass_cnt_q <= pass_cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      drop_q     <= drop_d;
    end
  end

  assign data_out          = data_q;
  assign data_valid_out    = valid_q;
  assign last_chunk_out    = last_q;
  assign input_dropped_out = drop_q;
  assign ready_out         = (state_q == S_LOAD);

endmodule

// File: tb/tb_number_chunk_replayer.sv
// Bench for number_chunk_replayer: scenario tasks compare the replayed stream
// against a stored copy of the loaded number and a count of remaining passes.
module tb_number_chunk_replayer;

  localparam int BITS = 128;
  localparam int RS   = 32;
  localparam int REP  = 2;
  localparam int N    = BITS / RS;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic [RS-1:0] data_in = '0;
  logic          data_valid_in = 1'b0;
  logic          request_next_input = 1'b0;
  logic [RS-1:0] data_out;
  logic          data_valid_out;
  logic          last_chunk_out;
  logic          ready_out;
  logic          input_dropped_out;

  int errors = 0;
  int checks = 0;

  logic [RS-1:0] model_mem [N];
  int            passes_left = 0;

  number_chunk_replayer #(
    .BITS_IN_NUM  (BITS),
    .REGISTER_SIZE(RS),
    .NUM_REPEATS  (REP)
  ) dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .data_in           (data_in),
    .data_valid_in     (data_valid_in),
    .request_next_input(request_next_input),
    .data_out          (data_out),
    .data_valid_out    (data_valid_out),
    .last_chunk_out    (last_chunk_out),
    .ready_out         (ready_out),
    .input_dropped_out (input_dropped_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) model_mem[i] = $urandom;
  endtask

  task automatic load_chunk(input logic [RS-1:0] v);
    data_in       = v;
    data_valid_in = 1'b1;
    checks++;
    if (ready_out !== 1'b1) begin
      errors++;
      $display("FAIL load_ready: ready_out=%b expected 1", ready_out);
    end
    cyc();
    data_valid_in = 1'b0;
  endtask

  task automatic load_model();
    for (int i = 0; i < N; i++) load_chunk(model_mem[i]);
    passes_left = REP;
    checks++;
    if (ready_out !== 1'b0) begin
      errors++;
      $display("FAIL load_done_ready: ready_out=%b expected 0", ready_out);
    end
  endtask

  // One request followed by a full pass; optional drop or extra request injected.
  task automatic run_pass(input bit req_on_last, input int drop_at);
    request_next_input = 1'b1;
    cyc();
    request_next_input = 1'b0;
    checks++;
    if (data_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL req_latency: data_valid_out=%b expected 0", data_valid_out);
    end
    for (int k = 0; k < N; k++) begin
      if (k == drop_at) begin
        data_in       = 32'hDEADBEEF;
        data_valid_in = 1'b1;
      end
      if (req_on_last && k == N - 1) request_next_input = 1'b1;
      cyc();
      data_valid_in      = 1'b0;
      request_next_input = 1'b0;
      checks++;
      if (data_valid_out !== 1'b1 || data_out !== model_mem[k]) begin
        errors++;
        $display("FAIL pass_chunk%0d: valid=%b data=%h expected valid=1 data=%h",
                 k, data_valid_out, data_out, model_mem[k]);
      end
      checks++;
      if (last_chunk_out !== (k == N - 1)) begin
        errors++;
        $display("FAIL pass_last%0d: last_chunk_out=%b expected %b", k, last_chunk_out, k == N - 1);
      end
      checks++;
      if (input_dropped_out !== (k == drop_at)) begin
        errors++;
        $display("FAIL pass_drop%0d: input_dropped_out=%b expected %b", k, input_dropped_out, k == drop_at);
      end
    end
    passes_left--;
    checks++;
    if (ready_out !== (passes_left == 0)) begin
      errors++;
      $display("FAIL pass_end_ready: ready_out=%b expected %b", ready_out, passes_left == 0);
    end
  endtask

  task automatic idle_no_output(input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      cyc();
      checks++;
      if (data_valid_out !== 1'b0 || last_chunk_out !== 1'b0) begin
        errors++;
        $display("FAIL %s: valid=%b last=%b expected 0 0", tag, data_valid_out, last_chunk_out);
      end
    end
  endtask

  task automatic test_reset();
    #3 rst_in = 1'b0;
    #1;
    checks++;
    if (data_valid_out !== 1'b0 || last_chunk_out !== 1'b0 || input_dropped_out !== 1'b0 ||
        data_out !== '0 || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%b last=%b drop=%b data=%h ready=%b expected 0 0 0 0 1",
               data_valid_out, last_chunk_out, input_dropped_out, data_out, ready_out);
    end
    repeat (2) @(posedge clk_in);
    #1 rst_in = 1'b1;
    cyc();
    checks++;
    if (ready_out !== 1'b1 || data_valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b valid=%b expected 1 0", ready_out, data_valid_out);
    end
  endtask

  task automatic test_basic();
    model_mem[0] = 32'h11111111;
    model_mem[1] = 32'h22222222;
    model_mem[2] = 32'h33333333;
    model_mem[3] = 32'h44444444;
    load_model();
    run_pass(1'b0, -1);
    run_pass(1'b0, -1);
  endtask

  task automatic test_latency_gap();
    fill_random();
    load_model();
    run_pass(1'b1, -1);
    idle_no_output(3, "ignored_req_on_last");
    run_pass(1'b0, -1);
    fill_random();
    load_model();
    run_pass(1'b0, -1);
    run_pass(1'b0, -1);
  endtask

  task automatic test_drops();
    fill_random();
    load_model();
    data_in       = 32'hDEADBEEF;
    data_valid_in = 1'b1;
    cyc();
    data_valid_in = 1'b0;
    checks++;
    if (input_dropped_out !== 1'b1 || ready_out !== 1'b0) begin
      errors++;
      $display("FAIL drop_wait: drop=%b ready=%b expected 1 0", input_dropped_out, ready_out);
    end
    cyc();
    checks++;
    if (input_dropped_out !== 1'b0) begin
      errors++;
      $display("FAIL drop_width: input_dropped_out=%b expected 0", input_dropped_out);
    end
    run_pass(1'b0, 1);
    run_pass(1'b0, N - 1);
  endtask

  task automatic test_ignored_req();
    fill_random();
    load_chunk(model_mem[0]);
    load_chunk(model_mem[1]);
    request_next_input = 1'b1;
    cyc();
    request_next_input = 1'b0;
    checks++;
    if (data_valid_out !== 1'b0 || ready_out !== 1'b1) begin
      errors++;
      $display("FAIL req_in_load: valid=%b ready=%b expected 0 1", data_valid_out, ready_out);
    end
    load_chunk(model_mem[2]);
    request_next_input = 1'b1;
    load_chunk(model_mem[3]);
    request_next_input = 1'b0;
    passes_left = REP;
    checks++;
    if (ready_out !== 1'b0) begin
      errors++;
      $display("FAIL ignored_load_done: ready_out=%b expected 0", ready_out);
    end
    idle_no_output(3, "no_pending_pass");
    run_pass(1'b0, -1);
    run_pass(1'b0, -1);
  endtask

  task automatic test_reset_mid_stream();
    fill_random();
    load_model();
    request_next_input = 1'b1;
    cyc();
    request_next_input = 1'b0;
    cyc();
    cyc();
    checks++;
    if (data_valid_out !== 1'b1 || data_out !== model_mem[1]) begin
      errors++;
      $display("FAIL pre_reset_chunk1: valid=%b data=%h expected 1 %h",
               data_valid_out, data_out, model_mem[1]);
    end
    #2 rst_in = 1'b0;
    #1;
    checks++;
    if (data_valid_out !== 1'b0 || ready_out !== 1'b1 || data_out !== '0) begin
      errors++;
      $display("FAIL async_reset: valid=%b ready=%b data=%h expected 0 1 0",
               data_valid_out, ready_out, data_out);
    end
    @(posedge clk_in);
    #1 rst_in = 1'b1;
    model_mem[0] = 32'hA;
    model_mem[1] = 32'hB;
    model_mem[2] = 32'hC;
    model_mem[3] = 32'hD;
    load_model();
    run_pass(1'b0, -1);
    run_pass(1'b0, -1);
  endtask

  task automatic test_back_to_back();
    fill_random();
    load_model();
    run_pass(1'b0, -1);
    run_pass(1'b0, -1);
    fill_random();
    load_model();
    run_pass(1'b0, -1);
    run_pass(1'b0, -1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_latency_gap();
    test_drops();
    test_ignored_req();
    test_reset_mid_stream();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
